ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
Parametrised EX/MEM pipeline register. Carries the same payload as the existing EX/MEM latch: WB control, M control, ALU result, store data, write-register index and Rd. Adds valid/ready handshake, flush (bubble insertion) and an optional skid entry, so a variable-latency data memory can stall the MEM stage without a combinational ready path back into EX. Sits between the ALU/forwarding logic and the data-memory stage.

Parameters:
DATA_W, 32, width of alu_result and write_mem_data
REG_W, 5, width of register indices
WB_W, 2, width of WB control field
M_W, 2, width of M control field
SKID_EN, 1, 1 = two-entry skid (registered in_ready); 0 = single entry (in_ready combinational)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX stage presents a beat
in_ready  out  1  stage can accept a beat this cycle
flush  in  1  squash all held beats and any beat accepted this cycle
wb_in  in  WB_W  WB control
m_in  in  M_W  M control
alu_result_in  in  DATA_W  ALU result
write_mem_data_in  in  DATA_W  store data
write_register_in  in  REG_W  destination register
rd_in  in  REG_W  Rd field
out_valid  out  1  MEM stage beat valid
out_ready  in  1  MEM stage consumes the beat
wb_out, m_out, alu_result_out, write_mem_data_out, write_register_out, rd_out  out  as inputs  registered payload
occupancy  out  2  beats held (0..2)

Behaviour:
- Reset (async, rst=1): out_valid=0, occupancy=0, every payload output 0. in_ready=1 from the first cycle after rst deasserts.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Storage: main entry drives the outputs; a skid entry exists only when SKID_EN=1.
- SKID_EN=1, in_ready = ~skid_valid (registered, no combinational path from out_ready):
  - Main empty, or consumed: main loads from skid if skid_valid, else from input if Accept.
  - Main full, not consumed, Accept: beat goes to skid.
  - Simultaneous Consume and Accept with skid full cannot occur, because in_ready=0.
- SKID_EN=0: in_ready = ~out_valid | out_ready. Main loads on Accept.
- Latency: empty stage, Accept at edge N gives out_valid=1 after edge N. Sustained throughput is 1 beat/cycle with out_ready held 1.
- Ordering is strictly FIFO. A beat is never duplicated or dropped except by flush.
- Bubble rule: while out_valid=0, wb_out and m_out read 0, so no regwrite or memwrite can leak. Data fields hold their last value.
- Flush (synchronous, sampled at the edge):
  - Clears main_valid and skid_valid and zeroes the stored WB/M fields.
  - Any beat accepted in the same cycle is discarded.
  - Flush dominates Accept and Consume. The MEM stage still sees the pre-edge beat during the flush cycle.
- occupancy = main_valid + skid_valid, updated at the same edge as the valid bits.
- rst asserted mid-transfer: state clears immediately, without waiting for a clock edge. Payload outputs go to 0 combinationally with rst.

Decomposition:
- Package ex_mem_pkg: default widths, typedef ex_mem_payload_t (packed struct: wb, m, alu_result, write_mem_data, write_register, rd), localparam PAYLOAD_W.
- One sub-module, pipe_skid_reg: generic payload-width skid register holding the valid/ready/flush logic.
- ex_mem_pipe packs and unpacks the struct and applies the WB/M bubble gating.

Test Plan:
- Reset: rst=1 mid-stream with occupancy=2 -> same cycle out_valid=0, all outputs 0, occupancy=0. First cycle after release in_ready=1.
- Pass-through: out_ready=1, beats alu=0x10,0x20,0x30 on consecutive cycles -> outputs appear 1 cycle later, back-to-back, in order, out_valid never drops.
- Back-pressure (SKID_EN=1): out_ready=0, send A,B,C -> A in main, B in skid, in_ready=0 after B, C held upstream, occupancy=2. out_ready=1 -> A, B, C emitted in order with no gaps.
- Flush: occupancy=2 and in_valid=1 with wb=2'b11 flush=1 -> next cycle out_valid=0, wb_out=0, m_out=0, occupancy=0. Squashed beat never emerges.
- SKID_EN=0: out_ready toggled 1,0,1,0 with continuous in_valid -> in_ready tracks ~out_valid|out_ready combinationally, occupancy never exceeds 1, no beat lost.
- Bubble gating: after consuming the last beat (wb=2'b01, m=2'b10) with in_valid=0 -> wb_out=0 and m_out=0 while alu_result_out keeps the last value.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared widths and payload layout for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned RegWDefault  = 5;
  localparam int unsigned WbWDefault   = 2;
  localparam int unsigned MWDefault    = 2;

  // Payload at default widths; wb sits in the MSBs so the control fields form one contiguous slice.
  typedef struct packed {
    logic [WbWDefault-1:0]   wb;
    logic [MWDefault-1:0]    m;
    logic [DataWDefault-1:0] alu_result;
    logic [DataWDefault-1:0] write_mem_data;
    logic [RegWDefault-1:0]  write_register;
    logic [RegWDefault-1:0]  rd;
  } ex_mem_payload_t;

  localparam int unsigned PAYLOAD_W = $bits(ex_mem_payload_t);

  // Payload width for non-default field widths, same field order as ex_mem_payload_t.
  function automatic int unsigned payload_width(input int unsigned wb_w, input int unsigned m_w,
                                                input int unsigned data_w,
                                                input int unsigned reg_w);
    return wb_w + m_w + 2 * data_w + 2 * reg_w;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_reg.sv
// Generic valid/ready pipeline register with optional skid entry and synchronous flush.
// The main entry drives the output; the skid entry catches the one beat that arrives while the
// main entry is stalled, which lets ready_o come straight from a flop.
module pipe_skid_reg #(
  parameter int unsigned      Width     = 8,
  parameter bit               SkidEn    = 1'b1,
  // Bits cleared in held entries on flush (control fields that must not leak).
  parameter logic [Width-1:0] FlushMask = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  logic             main_valid_q, main_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             accept, consume;

  // Skid mode: ready is purely registered. Single mode: ready looks through to the consumer.
  assign ready_o = SkidEn ? ~skid_valid_q : (~main_valid_q | ready_i);
  assign accept  = valid_i & ready_o;
  assign consume = main_valid_q & ready_i;

  assign valid_o     = main_valid_q;
  assign data_o      = main_data_q;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state: flush wins, otherwise refill main (skid first for ordering) or park in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = main_data_q & ~FlushMask;
      skid_data_d  = skid_data_q & ~FlushMask;
    end else if (SkidEn) begin
      if (!main_valid_q || consume) begin
        if (skid_valid_q) begin
          // ready_o is low while skid is full, so no accept can collide with this move.
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = data_i;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = data_i;
      end else if (consume) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush and optional skid entry.
// Packs the EX payload, stores it in pipe_skid_reg, and gates WB/M to zero on bubbles.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned REG_W   = RegWDefault,
  parameter int unsigned WB_W    = WbWDefault,
  parameter int unsigned M_W     = MWDefault,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_mem_data_in,
  input  logic [REG_W-1:0]  write_register_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_mem_data_out,
  output logic [REG_W-1:0]  write_register_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [1:0]        occupancy
);

  // Same field order as ex_mem_payload_t, resized to this instance's widths.
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_mem_data;
    logic [REG_W-1:0]  write_register;
    logic [REG_W-1:0]  rd;
  } payload_t;

  localparam int unsigned PayloadW = payload_width(WB_W, M_W, DATA_W, REG_W);
  localparam int unsigned CtrlW    = WB_W + M_W;
  // Flush zeroes the stored WB/M slice (MSBs) and leaves data fields alone.
  localparam logic [PayloadW-1:0] FlushMask = {{CtrlW{1'b1}}, {(PayloadW - CtrlW){1'b0}}};

  payload_t            in_pl, out_pl;
  logic [PayloadW-1:0] in_bits, out_bits;

  assign in_pl.wb             = wb_in;
  assign in_pl.m              = m_in;
  assign in_pl.alu_result     = alu_result_in;
  assign in_pl.write_mem_data = write_mem_data_in;
  assign in_pl.write_register = write_register_in;
  assign in_pl.rd             = rd_in;
  assign in_bits              = in_pl;

  pipe_skid_reg #(
    .Width    (PayloadW),
    .SkidEn   (SKID_EN),
    .FlushMask(FlushMask)
  ) u_reg (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (in_valid),
    .ready_o    (in_ready),
    .flush_i    (flush),
    .data_i     (in_bits),
    .valid_o    (out_valid),
    .ready_i    (out_ready),
    .data_o     (out_bits),
    .occupancy_o(occupancy)
  );

  assign out_pl = payload_t'(out_bits);

  // Bubbles must never carry regwrite/memwrite; data fields keep their last value.
  assign wb_out             = out_valid ? out_pl.wb : '0;
  assign m_out              = out_valid ? out_pl.m : '0;
  assign alu_result_out     = out_pl.alu_result;
  assign write_mem_data_out = out_pl.write_mem_data;
  assign write_register_out = out_pl.write_register;
  assign rd_out             = out_pl.rd;

endmodule
